// File: rtl/vga_output_stage.sv
// vga_output_stage
//
// Display back end for the VGA path. Owns the pixel-clock divider and the
// raster counters, publishes the current raster position to the upstream
// pixel stage, and registers that stage's colour together with the sync
// and blanking signals, delayed so that all DAC-side pins stay aligned.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   rgb_in       in   24-bit upstream colour {R,G,B}, valid PIPE_DELAY ticks
//                     after the matching pix_x/pix_y
//   pix_x/pix_y  out  current raster position (0..H_TOTAL-1, 0..V_TOTAL-1)
//   pix_tick     out  one-clk strobe marking a pixel advance
//   frame_start  out  one-clk strobe on the tick at raster position (0,0)
//   vga_r/g/b    out  registered colour, forced to zero outside the visible area
//   hsync/vsync  out  active-low sync pulses
//   blank_n      out  low outside the visible region
//   vga_clk      out  pixel clock to the DAC
module vga_output_stage #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned PIPE_DELAY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] rgb_in,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_tick,
    output logic        frame_start,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic        vga_clk
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_VISIBLE);
    localparam logic [9:0] V_ACT  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;

    // Delay line for {hs, vs, act}; index PIPE_DELAY-1 is the oldest stage.
    logic [PIPE_DELAY-1:0] hs_pipe_q;
    logic [PIPE_DELAY-1:0] vs_pipe_q;
    logic [PIPE_DELAY-1:0] act_pipe_q;

    logic hs_cur;
    logic vs_cur;
    logic act_cur;

    // Divider and raster counters
    assign pix_tick = (div_q == DIV_LAST);
    assign vga_clk  = div_q[DIV_W-1];

    always_comb begin
        div_d = pix_tick ? '0 : div_q + DIV_W'(1);
        h_d   = h_q;
        v_d   = v_q;
        if (pix_tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    assign pix_x       = h_q;
    assign pix_y       = v_q;
    // Not delayed: marks the position being published, not the pixel on the pins.
    assign frame_start = pix_tick && (h_q == '0) && (v_q == '0);

    // Decode of the position currently being published
    assign hs_cur  = !((h_q >= HS_BEG) && (h_q <= HS_END));
    assign vs_cur  = !((v_q >= VS_BEG) && (v_q <= VS_END));
    assign act_cur = (h_q < H_ACT) && (v_q < V_ACT);

    // Reset loads the idle timing so no stale sync pulse leaks out after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_pipe_q  <= '1;
            vs_pipe_q  <= '1;
            act_pipe_q <= '0;
        end else if (pix_tick) begin
            hs_pipe_q[0]  <= hs_cur;
            vs_pipe_q[0]  <= vs_cur;
            act_pipe_q[0] <= act_cur;
            for (int k = 1; k < PIPE_DELAY; k++) begin
                hs_pipe_q[k]  <= hs_pipe_q[k-1];
                vs_pipe_q[k]  <= vs_pipe_q[k-1];
                act_pipe_q[k] <= act_pipe_q[k-1];
            end
        end
    end

    // DAC-side output registers; rgb_in is sampled on the same tick edge that
    // the matching timing bits leave the delay line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            blank_n <= 1'b0;
            vga_r   <= '0;
            vga_g   <= '0;
            vga_b   <= '0;
        end else if (pix_tick) begin
            hsync   <= hs_pipe_q[PIPE_DELAY-1];
            vsync   <= vs_pipe_q[PIPE_DELAY-1];
            blank_n <= act_pipe_q[PIPE_DELAY-1];
            if (act_pipe_q[PIPE_DELAY-1]) begin
                vga_r <= rgb_in[23:16];
                vga_g <= rgb_in[15:8];
                vga_b <= rgb_in[7:0];
            end else begin
                vga_r <= '0;
                vga_g <= '0;
                vga_b <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_output_stage.sv
// Bench for vga_output_stage: three instances run side by side on one clock
// (default timing, a shrunken raster for whole-frame behaviour, and
// CLK_DIV=4/PIPE_DELAY=1). Expected outputs are computed per tick from the
// raster rules and queued; a monitor per instance pops and compares.
module tb_vga_output_stage;

    localparam int N_INST = 3;
    localparam int P_HV  [N_INST] = '{640, 20, 640};
    localparam int P_HF  [N_INST] = '{16, 2, 16};
    localparam int P_HS  [N_INST] = '{96, 4, 96};
    localparam int P_HB  [N_INST] = '{48, 3, 48};
    localparam int P_VV  [N_INST] = '{480, 10, 480};
    localparam int P_VF  [N_INST] = '{10, 2, 10};
    localparam int P_VS  [N_INST] = '{2, 2, 2};
    localparam int P_VB  [N_INST] = '{33, 3, 33};
    localparam int P_DIV [N_INST] = '{2, 2, 4};
    localparam int P_PD  [N_INST] = '{2, 3, 1};

    typedef enum logic [1:0] {ModeRand, ModeAlign, ModeWhite} mode_e;
    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        bl;
        logic [23:0] rgb;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [N_INST-1:0] done_w;

    task automatic check(input string name, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL inst%0d %s: got 0x%0h, expected 0x%0h", inst, name, act, exp);
        end
    endtask

    for (genvar g = 0; g < N_INST; g++) begin : g_inst
        localparam int HV  = P_HV[g];
        localparam int HF  = P_HF[g];
        localparam int HS  = P_HS[g];
        localparam int VV  = P_VV[g];
        localparam int VF  = P_VF[g];
        localparam int VS  = P_VS[g];
        localparam int DIV = P_DIV[g];
        localparam int PD  = P_PD[g];
        localparam int HT  = HV + HF + HS + P_HB[g];
        localparam int VT  = VV + VF + VS + P_VB[g];

        logic        rst;
        logic [23:0] rgb_in;
        logic [9:0]  pix_x, pix_y;
        logic        pix_tick, frame_start, hsync, vsync, blank_n, vga_clk;
        logic [7:0]  vga_r, vga_g, vga_b;

        vga_output_stage #(
            .H_VISIBLE (HV),
            .H_FRONT   (HF),
            .H_SYNC    (HS),
            .H_BACK    (P_HB[g]),
            .V_VISIBLE (VV),
            .V_FRONT   (VF),
            .V_SYNC    (VS),
            .V_BACK    (P_VB[g]),
            .CLK_DIV   (DIV),
            .PIPE_DELAY(PD)
        ) u_dut (
            .clk        (clk),
            .reset      (rst),
            .rgb_in     (rgb_in),
            .pix_x      (pix_x),
            .pix_y      (pix_y),
            .pix_tick   (pix_tick),
            .frame_start(frame_start),
            .vga_r      (vga_r),
            .vga_g      (vga_g),
            .vga_b      (vga_b),
            .hsync      (hsync),
            .vsync      (vsync),
            .blank_n    (blank_n),
            .vga_clk    (vga_clk)
        );

        exp_t  exp_q[$];
        int    k;          // clk edges since reset release
        mode_e mode;
        logic  align_en;
        logic  inst_done;
        assign done_w[g] = inst_done;

        // Pins after tick m show the pixel published PD ticks earlier.
        function automatic exp_t model(int m, logic [23:0] rgb);
            exp_t e;
            int p, x, y;
            p = m - PD;
            e = {1'b1, 1'b1, 1'b0, 24'h0};
            if (p >= 0) begin
                x = p % HT;
                y = (p / HT) % VT;
                e.hs  = !(x >= HV + HF && x < HV + HF + HS);
                e.vs  = !(y >= VV + VF && y < VV + VF + VS);
                e.bl  = (x < HV) && (y < VV);
                e.rgb = e.bl ? rgb : 24'h0;
            end
            return e;
        endfunction

        function automatic logic [23:0] align_rgb(int m);
            int p, x, y;
            p = m - PD;
            if (p < 0) return 24'h0;
            x = p % HT;
            y = (p / HT) % VT;
            return {8'(x), 8'(y), 8'hA5};
        endfunction

        task automatic step();
            int m, x, y;
            logic tk;
            logic [23:0] rgb;
            @(negedge clk);
            k++;
            m  = k / DIV;
            x  = m % HT;
            y  = (m / HT) % VT;
            tk = (k % DIV) == DIV - 1;
            check("pix_tick", g, 32'(pix_tick), 32'(tk));
            check("vga_clk", g, 32'(vga_clk), 32'((k % DIV) >= DIV / 2));
            check("pix_x", g, 32'(pix_x), x);
            check("pix_y", g, 32'(pix_y), y);
            check("frame_start", g, 32'(frame_start), 32'(tk && x == 0 && y == 0));
            if (tk) begin
                case (mode)
                    ModeRand:  rgb = 24'($urandom);
                    ModeAlign: rgb = align_rgb(m);
                    default:   rgb = 24'hFFFFFF;
                endcase
                rgb_in = rgb;
                exp_q.push_back(model(m, rgb));
            end
        endtask

        // Asserted between edges; outputs must clear before any clock edge.
        task automatic hit_reset();
            #2 rst = 1'b1;
            #1;
            check("reset timing pins", g,
                  {6'b0, pix_x, pix_y, pix_tick, frame_start, vga_clk, hsync, vsync, blank_n},
                  {6'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
            check("reset colour", g, {8'b0, vga_r, vga_g, vga_b}, 32'h0);
        endtask

        task automatic drop_reset();
            @(negedge clk);
            #2;
            k   = 0;
            rst = 1'b0;
        endtask

        initial begin
            rst       = 1'b1;
            rgb_in    = '0;
            k         = 0;
            mode      = ModeRand;
            align_en  = 1'b0;
            inst_done = 1'b0;
            repeat (2) @(negedge clk);
            if (g == 1) mode = ModeWhite;
            drop_reset();
            if (g == 0) begin
                while (k / DIV < 3 * HT + 300) step();
                hit_reset();
                repeat (2) @(negedge clk);
                mode     = ModeAlign;
                align_en = 1'b1;
                drop_reset();
                while (k < 7 * HT * DIV) step();
            end else if (g == 1) begin
                while (k < 2 * VT * HT * DIV + 300) step();
                hit_reset();
                repeat (2) @(negedge clk);
                mode = ModeRand;
                drop_reset();
                while (k < VT * HT * DIV + 200) step();
            end else begin
                while (k < 2 * HT * DIV + 100) step();
            end
            @(negedge clk);
            #1 inst_done = 1'b1;
        end

        logic tick_d;
        always @(posedge clk or posedge rst) begin
            if (rst) tick_d <= 1'b0;
            else     tick_d <= pix_tick;
        end

        exp_t       cur;
        int         cyc, hs_fall, bl_rise, vs_fall, fs_last, n_rise;
        logic       hs_p, bl_p, vs_p;
        logic [9:0] py_p;

        always @(negedge clk) begin
            if (rst) begin
                cur = {1'b1, 1'b1, 1'b0, 24'h0};
                exp_q.delete();
                cyc = 0; hs_fall = -1; bl_rise = -1; vs_fall = -1; fs_last = -1; n_rise = 0;
                hs_p = 1'b1; bl_p = 1'b0; vs_p = 1'b1; py_p = '0;
            end else if (!inst_done) begin
                cyc++;
                if (tick_d) begin
                    check("tick has expectation", g, 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) cur = exp_q.pop_front();
                end
                check("output pins", g, {5'b0, hsync, vsync, blank_n, vga_r, vga_g, vga_b},
                      {5'b0, cur});
                if (!blank_n) check("blanked colour", g, {8'b0, vga_r, vga_g, vga_b}, 32'h0);

                if (hs_p && !hsync) begin
                    if (hs_fall >= 0) check("hsync period", g, cyc - hs_fall, HT * DIV);
                    else check("first hsync fall", g, cyc, (HV + HF + PD + 1) * DIV);
                    hs_fall = cyc;
                end
                if (!hs_p && hsync && hs_fall >= 0)
                    check("hsync low width", g, cyc - hs_fall, HS * DIV);

                if (!bl_p && blank_n) begin
                    bl_rise = cyc;
                    n_rise++;
                    if (align_en && n_rise == 6)
                        check("line 5 first colour", g, {8'b0, vga_r, vga_g, vga_b}, 32'h0005A5);
                end
                if (bl_p && !blank_n && bl_rise >= 0)
                    check("blank_n high width", g, cyc - bl_rise, HV * DIV);

                if (vs_p && !vsync) begin
                    if (vs_fall >= 0) check("vsync period", g, cyc - vs_fall, VT * HT * DIV);
                    vs_fall = cyc;
                end
                if (!vs_p && vsync && vs_fall >= 0)
                    check("vsync low width", g, cyc - vs_fall, VS * HT * DIV);

                if (frame_start) begin
                    if (fs_last >= 0) check("frame_start spacing", g, cyc - fs_last, VT * HT * DIV);
                    else check("first frame_start", g, cyc, DIV - 1);
                    fs_last = cyc;
                end

                if (pix_y != py_p) check("pix_y step", g, 32'(pix_y), (32'(py_p) + 1) % VT);

                hs_p = hsync;
                bl_p = blank_n;
                vs_p = vsync;
                py_p = pix_y;
            end
        end
    end

    initial begin
        for (int i = 0; i < 60000 && done_w != '1; i++) @(negedge clk);
        check("all instances finished", 0, 32'(done_w == '1), 32'd1);
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_output_stage.md
# vga_output_stage

Display back end for the VGA path. Owns the 800×525 raster counters and the pixel-clock divider, and publishes the current raster position to the sprite/pixel stage upstream. Samples that stage's 24-bit colour after a fixed pipeline delay and drives the DAC-side pins: registered RGB, hsync, vsync, blank_n and vga_clk. All timing outputs are delayed to stay aligned with the colour data.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- H_SYNC, 96, hsync pulse width in pixels
- H_BACK, 48, horizontal back porch in pixels (H_TOTAL = 800)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 33, vertical back porch in lines (V_TOTAL = 525)
- CLK_DIV, 2, clk cycles per pixel; must be a power of two and at least 2
- PIPE_DELAY, 2, pixel ticks from pix_x/pix_y to valid rgb_in; range 1..4
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rgb_in  in  24  upstream colour {R,G,B}
- pix_x  out  10  current horizontal count, 0..H_TOTAL-1
- pix_y  out  10  current vertical count, 0..V_TOTAL-1
- pix_tick  out  1  one-clk strobe marking a pixel advance
- frame_start  out  1  one-clk strobe when pix_x=0, pix_y=0 and pix_tick=1
- vga_r, vga_g, vga_b  out  8 each  registered colour to the DAC
- hsync, vsync  out  1 each  active-low sync
- blank_n  out  1  low outside the visible region
- vga_clk  out  1  pixel clock to the DAC

## Operation
- **Divider:** div counts 0..CLK_DIV-1 and wraps.
  - pix_tick = (div == CLK_DIV-1), decoded from the register.
  - vga_clk = MSB of div.
- **Raster counters:** all counter state changes only on clk edges where pix_tick=1.
  - h_cnt increments each tick.
  - At h_cnt = H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At v_cnt = V_TOTAL-1 with h_cnt wrapping, v_cnt wraps to 0.
  - pix_x = h_cnt and pix_y = v_cnt, driven directly from the registers.
- **Decode of the current (h_cnt, v_cnt):**
  - hs = 0 for h in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (656..751).
  - vs = 0 for v in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (490..491).
  - act = (h < H_VISIBLE) && (v < V_VISIBLE).
- **Delay line:** PIPE_DELAY stages of {hs, vs, act}, shifted only on pix_tick.
  - Stage 0 captures the decode.
  - Stage k captures stage k-1.
- **Output registers (update on pix_tick only):**
  - hsync, vsync and blank_n take the last delay stage.
  - vga_r/g/b take rgb_in[23:16]/[15:8]/[7:0] when the last stage's act=1, else 0.
  - Colour is never passed through outside the visible region, whatever rgb_in carries.
- **frame_start:** asserted combinationally in the clk cycle where pix_tick=1, h_cnt=0 and v_cnt=0. It is not delayed.

## Timing
- **Reset values** (asynchronous, immediate on reset):
  - div=0, h_cnt=0, v_cnt=0, so pix_x=0 and pix_y=0.
  - pix_tick=0 and vga_clk=0.
  - All delay stages hold {hs=1, vs=1, act=0}.
  - hsync=1, vsync=1, blank_n=0, vga_r/g/b=0.
  - frame_start=0.
- **After reset release:**
  - The first pix_tick occurs in clk cycle CLK_DIV-1 (cycle 1 at default).
  - frame_start pulses in that same cycle.
- **Latency:** colour and sync for the pixel shown on pix_x/pix_y at tick n appear on the outputs after the tick n+PIPE_DELAY edge. rgb_in is sampled on that edge.
- **Period arithmetic at default parameters:**
  - Line period is 800 ticks = 1600 clk.
  - hsync low for 96 ticks = 192 clk.
  - vsync low for 2 lines = 3200 clk.
  - Frame period is 420000 ticks = 840000 clk.
- **Counter widths:** 10 bits. H_TOTAL and V_TOTAL must be ≤ 1024. Wrap is by compare, never by overflow.
- **Reset mid-frame:** everything returns to reset values at once. The first frame after reset starts cleanly at (0,0), with no partial sync pulse carried over from the delay line.

## Test plan
- **Reset:** assert reset mid-line at h=300, v=100 -> all outputs immediately take their reset values. After release, pix_tick goes high 1 clk later and frame_start pulses with pix_x=0, pix_y=0.
- **Line timing:** run 2 lines -> hsync falls every 1600 clk and stays low exactly 192 clk. blank_n is high for 1280 clk per visible line.
- **Frame timing:** run 2 frames -> vsync is low exactly 3200 clk, once per 840000 clk. frame_start pulses exactly once per frame. pix_y wraps 524 -> 0.
- **Alignment:** drive rgb_in = {pix_x[7:0], pix_y[7:0], 8'hA5}, delayed 2 ticks by the bench model. The first visible vga_r/g/b of line 5 must read 00/05/A5, appearing on the same tick edge that blank_n rises.
- **Blanking:** hold rgb_in = FFFFFF for a whole frame -> vga_r/g/b = 0 whenever blank_n=0, including in the porches and during vsync lines.
- **Parameter sweep:** run CLK_DIV=4, PIPE_DELAY=1 -> line period 3200 clk. vga_clk has period 4 clk with 50% duty. Colour latency is 1 tick.
